// File: rtl/wash_dry_timer.sv
// Wash/dry phase timer: a shared prescaler ticks the wash and dry counters, which saturate at their targets.
// Optional WASH_TIMER_REMAIN_EN macro adds the `remain` output (ticks left in the active phase).
module wash_dry_timer #(
  parameter int PRESCALE   = 4,
  parameter int CNT_W      = 8,
  parameter int WASH_TICKS = 3,
  parameter int DRY_TICKS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             water_pump,
  input  logic             drying_fan,
  output logic             comp_time,
`ifdef WASH_TIMER_REMAIN_EN
  output logic             comp_time2,
  output logic [CNT_W-1:0] remain
`else
  output logic             comp_time2
`endif
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] WASH_MAX = CNT_W'(WASH_TICKS);
  localparam logic [CNT_W-1:0] DRY_MAX  = CNT_W'(DRY_TICKS);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_wash_cnt;
  logic [CNT_W-1:0] r_dry_cnt;

  logic             w_en;
  logic             w_tick;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [CNT_W-1:0] w_wash_nxt;
  logic [CNT_W-1:0] w_dry_nxt;

  assign w_en   = water_pump | drying_fan;
  // With PRESCALE=1 the prescaler is stuck at 0, so every enabled cycle ticks.
  assign w_tick = w_en & (r_pre == PRE_MAX);

  always_comb begin
    w_pre_nxt  = r_pre;
    w_wash_nxt = r_wash_cnt;
    w_dry_nxt  = r_dry_cnt;
    if (w_tick) begin
      w_pre_nxt = '0;
    end else if (w_en) begin
      w_pre_nxt = r_pre + 1'b1;
    end
    if (w_tick && water_pump && (r_wash_cnt != WASH_MAX)) begin
      w_wash_nxt = r_wash_cnt + 1'b1;
    end
    if (w_tick && drying_fan && (r_dry_cnt != DRY_MAX)) begin
      w_dry_nxt = r_dry_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_pre      <= '0;
      r_wash_cnt <= '0;
      r_dry_cnt  <= '0;
    end else begin
      r_pre      <= w_pre_nxt;
      r_wash_cnt <= w_wash_nxt;
      r_dry_cnt  <= w_dry_nxt;
    end
  end

  // Completion flags are decoded from registers only; they hold until clear/reset.
  assign comp_time  = (r_wash_cnt == WASH_MAX);
  assign comp_time2 = (r_dry_cnt == DRY_MAX);

`ifdef WASH_TIMER_REMAIN_EN
  assign remain = drying_fan ? (DRY_MAX - r_dry_cnt) : (WASH_MAX - r_wash_cnt);
`endif

endmodule
